pwm_multi_apb: RTL
==================

// Module: pwm_multi_apb
// PURPOSE
// - APB3 slave generating NCH edge-aligned PWM outputs from one shared period counter.
// - Generalises the single-channel LED/servo PWM: per-channel duty, polarity and enable,
//   plus a programmable period. Shadow registers update only at the period wrap, so no glitches.
// - Sits on the Cortex-M3 fabric APB alongside the other lockNET peripherals.
// PARAMETERS
// - NCH         4       number of PWM channels (1..16)
// - CNT_W       24      counter/period/duty width in bits (8..32)
// - DEF_PERIOD  125000  reset value of PERIOD (must fit CNT_W)
// PORTS
// - PCLK     in   1      APB clock; the only clock
// - PRESET   in   1      asynchronous, active-high reset
// - PSEL     in   1      peripheral select
// - PENABLE  in   1      APB access phase
// - PWRITE   in   1      1=write, 0=read
// - PADDR    in   32     byte address; only PADDR[7:2] is decoded
// - PWDATA   in   32     write data
// - PRDATA   out  32     read data, combinational from PADDR
// - PREADY   out  1      tied 1 (zero wait states)
// - PSLVERR  out  1      1 during access phase to an unmapped offset
// - pwm_out  out  NCH    registered PWM outputs
// - irq      out  1      period-wrap interrupt (PWM_IRQ_EN builds only)
// BEHAVIOUR
// - Write strobe is PSEL&PENABLE&PWRITE. Unmapped writes are ignored; unmapped reads return 0.
//   Data bits above CNT_W/NCH are read as 0 and ignored on write.
// - Map: 0x00 CTRL = [31] RUN, [30] IRQ_EN, [NCH-1:0] channel enable; 0x04 PERIOD (shadow);
//   0x08 STATUS = [31:8] live count (read only), [0] WRAP flag (W1C); 0x0C POL [NCH-1:0];
//   0x10+4*i DUTY[i] (shadow).
// - Reset: CTRL=0, POL=0, PERIOD shadow/active=DEF_PERIOD, all DUTY=0, count=0, WRAP=0,
//   pwm_out=0, irq=0.
// - Counter: while RUN=1, count 0..period_act inclusive, giving a period of period_act+1 cycles.
//   At count==period_act the next count is 0 (the wrap).
// - Shadow load: on the wrap cycle, period_act<=PERIOD and duty_act[i]<=DUTY[i], effective from count=0.
//   While RUN=0, count is held at 0 and the active registers copy the shadows every cycle.
// - A write to a shadow on the wrap cycle itself takes effect at this wrap: the new PWDATA is loaded.
// - Output: pwm_out[i] <= (EN[i] & RUN & (count < duty_act[i])) ^ POL[i]. One cycle of latency
//   from count. A disabled channel idles at POL[i].
// - Boundaries: duty 0 gives constant inactive. duty > period_act gives constant active.
//   period 0 holds count at 0 with a 1-cycle period, so output is active iff duty>0.
// - Clearing RUN mid-period: count returns to 0 on the next cycle and outputs go to POL level.
//   Setting RUN restarts from count 0.
// - WRAP flag sets on every wrap. Writing 1 to STATUS[0] clears it. Simultaneous set and clear: set wins.
// - Asynchronous PRESET mid-period: all state returns to reset values immediately.
// CONFIGURATION
// - PWM_IRQ_EN defined: irq = WRAP & IRQ_EN, registered; CTRL[30] is read/write.
// - PWM_IRQ_EN undefined: no irq port. The WRAP flag and STATUS still exist.
//   CTRL[30] reads 0 and ignores writes.
// TESTING
// - Reset, then read all registers -> CTRL=0, PERIOD=125000, DUTY=0, POL=0, pwm_out=0, PSLVERR=0.
// - PERIOD=9, DUTY0=3, CTRL=0x80000001 -> pwm_out[0] high 3 of every 10 cycles; channels 1..3 stay low.
// - Running with DUTY0=3: write DUTY0=7 mid-period -> current period keeps 3 high cycles;
//   the next period has 7.
// - DUTY1=0 / DUTY1=10 (PERIOD=9), POL[1]=1 -> constant 1 / constant 0. PERIOD=0, DUTY2=1 -> constant high.
// - IRQ build, IRQ_EN=1: after wrap, irq=1. Write STATUS=1 on a wrap cycle -> flag stays set.
//   A clean W1C -> irq=0 next cycle.
// - Read/write offset 0x40 -> PSLVERR=1, PRDATA=0, no state change. Assert PRESET mid-period
//   -> pwm_out=0 at once.

Source files
------------

// File: rtl/pwm_multi_apb.sv
// pwm_multi_apb: APB3 slave driving NCH edge-aligned PWM channels from one counter.
// Optional build macro PWM_IRQ_EN adds the registered irq output and CTRL[30].
module pwm_multi_apb #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 24,
  parameter int DEF_PERIOD = 125000
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  output logic [NCH-1:0]   pwm_out
`ifdef PWM_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

  logic [5:0]       w_idx;
  logic             w_acc;
  logic             w_wr;
  logic             w_mapped;
  logic             w_wr_ctrl;
  logic             w_wr_per;
  logic             w_wr_stat;
  logic             w_wr_pol;
  logic [NCH-1:0]   w_wr_duty;

  logic             r_run;
  logic [NCH-1:0]   r_en;
  logic [NCH-1:0]   r_pol;
  logic             w_irq_en;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_per_act;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_per_nxt;
  logic [CNT_W-1:0] r_duty     [NCH];
  logic [CNT_W-1:0] r_duty_act [NCH];
  logic [CNT_W-1:0] w_duty_nxt [NCH];
  logic [NCH-1:0]   r_pwm;

  logic             w_wrap;
  logic             w_load;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic [31:0]      w_cnt32;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_idx     = PADDR[7:2];
  assign w_acc     = PSEL & PENABLE;
  assign w_wr      = w_acc & PWRITE;
  assign w_mapped  = (w_idx < 6'(4 + NCH));
  assign w_wr_ctrl = w_wr && (w_idx == 6'd0);
  assign w_wr_per  = w_wr && (w_idx == 6'd1);
  assign w_wr_stat = w_wr && (w_idx == 6'd2);
  assign w_wr_pol  = w_wr && (w_idx == 6'd3);

  assign w_wrap = r_run && (r_cnt == r_per_act);
  assign w_load = !r_run || w_wrap;

  // A shadow write landing on the load cycle is forwarded into the active copy
  assign w_per_nxt  = w_wr_per ? PWDATA[CNT_W-1:0] : r_period;
  assign w_wrap_nxt = w_wrap | (r_wrap & ~(w_wr_stat & PWDATA[0]));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_run     <= 1'b0;
      r_en      <= '0;
      r_pol     <= '0;
      r_period  <= DEF_P;
      r_per_act <= DEF_P;
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_run <= PWDATA[31];
        r_en  <= PWDATA[NCH-1:0];
      end
      if (w_wr_per)
        r_period <= PWDATA[CNT_W-1:0];
      if (w_wr_pol)
        r_pol <= PWDATA[NCH-1:0];
      if (!r_run || w_wrap)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_load)
        r_per_act <= w_per_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_wr_duty[g]  = w_wr && (w_idx == 6'(4 + g));
    assign w_duty_nxt[g] = w_wr_duty[g] ? PWDATA[CNT_W-1:0]
                                        : r_duty[g];

    always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
        r_duty[g]     <= '0;
        r_duty_act[g] <= '0;
        r_pwm[g]      <= 1'b0;
      end else begin
        if (w_wr_duty[g])
          r_duty[g] <= PWDATA[CNT_W-1:0];
        if (w_load)
          r_duty_act[g] <= w_duty_nxt[g];
        r_pwm[g] <= (r_en[g] & r_run &
                     (r_cnt < r_duty_act[g])) ^ r_pol[g];
      end
    end
  end

`ifdef PWM_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  // irq tracks the flag and enable as they will be after this edge
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl)
        r_irq_en <= PWDATA[30];
      r_irq <= w_wrap_nxt &
               (w_wr_ctrl ? PWDATA[30] : r_irq_en);
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  assign w_cnt32 = 32'(r_cnt);

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      6'd0: w_rdata = {r_run, w_irq_en, 30'(r_en)};
      6'd1: w_rdata = 32'(r_period);
      6'd2: w_rdata = {w_cnt32[23:0], 7'd0, r_wrap};
      6'd3: w_rdata = 32'(r_pol);
      default: begin
        for (int i = 0; i < NCH; i++)
          if (w_idx == 6'(4 + i))
            w_rdata = 32'(r_duty[i]);
      end
    endcase
  end

  assign PRDATA  = w_rdata;
  assign PREADY  = 1'b1;
  assign PSLVERR = w_acc & ~w_mapped;
  assign pwm_out = r_pwm;

  assign w_unused = ^{PADDR[31:8], PADDR[1:0],
                      PWDATA, w_cnt32[31:24]};

endmodule
